// File: rtl/burst_mem_arbiter.sv
// Arbitrates 256-bit cacheline transactions from the split L1 caches onto a
// single 64-bit burst-memory port, four beats per line.
module burst_mem_arbiter #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_read,
    input  logic [ADDR_WIDTH-1:0]  i_addr,
    output logic [LINE_WIDTH-1:0]  i_rdata,
    output logic                   i_resp,
    input  logic                   d_read,
    input  logic                   d_write,
    input  logic [ADDR_WIDTH-1:0]  d_addr,
    input  logic [LINE_WIDTH-1:0]  d_wdata,
    output logic [LINE_WIDTH-1:0]  d_rdata,
    output logic                   d_resp,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [BURST_WIDTH-1:0] mem_wdata,
    input  logic [BURST_WIDTH-1:0] mem_rdata,
    input  logic                   mem_resp
);

    localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  own_d_q, own_d_d;   // 1 = dcache owns the transaction
    logic                  d_req;
    logic [ADDR_WIDTH-1:0] sel_addr;

    assign d_req    = d_write | d_read;
    assign sel_addr = d_req ? d_addr : i_addr;
    assign i_rdata  = line_q;
    assign d_rdata  = line_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            own_d_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            own_d_q <= own_d_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        line_d    = line_q;
        addr_d    = addr_q;
        own_d_d   = own_d_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Fixed priority: d_write > d_read > i_read
                if (d_req || i_read) begin
                    own_d_d = d_req;
                    addr_d  = sel_addr & ~LINE_MASK;
                    cnt_d   = '0;
                    if (d_write) begin
                        line_d  = d_wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                if (mem_resp) begin
                    line_d[BURST_WIDTH*int'(cnt_q) +: BURST_WIDTH] = mem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = line_q[BURST_WIDTH*int'(cnt_q) +: BURST_WIDTH];
                if (mem_resp) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) state_d = DONE;
                end
            end
            DONE: begin
                i_resp  = ~own_d_q;
                d_resp  = own_d_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_burst_mem_arbiter.sv
// Bench for burst_mem_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_burst_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, d_write, mem_resp;
    logic [31:0]  i_addr, d_addr;
    logic [255:0] d_wdata, i_rdata, d_rdata;
    logic         i_resp, d_resp, mem_read, mem_write;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    burst_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one outstanding line transaction, counted in beats
    bit           m_busy, m_resp, m_wr, m_own;
    logic [31:0]  m_addr;
    int           m_beats;
    logic [255:0] m_line;

    task automatic m_reset();
        m_busy = 0; m_resp = 0; m_wr = 0; m_own = 1;
        m_addr = '0; m_beats = 0; m_line = '0;
    endtask

    task automatic model_step();
        if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (mem_resp) begin
                if (!m_wr) m_line[64*m_beats +: 64] = mem_rdata;
                m_beats++;
                if (m_beats == 4) begin
                    m_busy = 0;
                    m_resp = 1;
                end
            end
        end else if (d_write || d_read || i_read) begin
            m_busy  = 1;
            m_beats = 0;
            m_own   = d_write || d_read;
            m_wr    = d_write;
            m_addr  = (m_own ? d_addr : i_addr) & ~32'h1F;
            if (d_write) m_line = d_wdata;
        end
    endtask

    task automatic check_outputs();
        chk("mem_read",  256'(mem_read),  256'(m_busy && !m_wr));
        chk("mem_write", 256'(mem_write), 256'(m_busy && m_wr));
        chk("mem_addr",  256'(mem_addr),  256'(m_busy ? m_addr : 32'h0));
        if (m_busy && m_wr) chk("mem_wdata", 256'(mem_wdata), 256'(m_line[64*m_beats +: 64]));
        chk("i_resp", 256'(i_resp), 256'(m_resp && !m_own));
        chk("d_resp", 256'(d_resp), 256'(m_resp && m_own));
        if (m_resp) begin
            if (m_own) chk("d_rdata", d_rdata, m_line);
            else       chk("i_rdata", i_rdata, m_line);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_i_resp"},    256'(i_resp),    '0);
        chk({tag, "_d_resp"},    256'(d_resp),    '0);
        chk({tag, "_mem_read"},  256'(mem_read),  '0);
        chk({tag, "_mem_write"}, 256'(mem_write), '0);
        chk({tag, "_mem_addr"},  256'(mem_addr),  '0);
        chk({tag, "_mem_wdata"}, 256'(mem_wdata), '0);
        chk({tag, "_i_rdata"},   i_rdata,         '0);
        chk({tag, "_d_rdata"},   d_rdata,         '0);
    endtask

    // Memory agent: scripted beats with programmable first-beat latency and gaps
    bit          dir_mode;
    logic [63:0] dir_beats [4];
    logic [63:0] wlog [4];
    int          dir_lat, dir_gap, wcnt, bidx, t_beat4;

    task automatic drive_mem();
        if (!dir_mode) begin
            mem_resp  = (mem_read || mem_write) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_rdata = {$urandom, $urandom};
        end else if (mem_read || mem_write) begin
            if (wcnt > 0) begin
                wcnt--;
                mem_resp  = 0;
                mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end else begin
                mem_resp  = 1;
                mem_rdata = dir_beats[bidx];
                wlog[bidx] = mem_wdata;
                if (bidx == 3) t_beat4 = cyc;
                bidx = (bidx + 1) % 4;
                wcnt = dir_gap;
            end
        end else begin
            mem_resp = 0;
            wcnt     = dir_lat;
        end
    endtask

    int           n_i, n_d, t_iresp, t_dresp, n_st;
    logic [255:0] i_line, d_line;
    logic [31:0]  st_addr [8];
    int           st_cyc [8];
    bit           prev_busy;

    task automatic clr_log();
        n_i = 0; n_d = 0; t_iresp = -1; t_dresp = -1; n_st = 0;
        i_line = '0; d_line = '0; bidx = 0;
        prev_busy = mem_read || mem_write;
    endtask

    task automatic run_dir(input int maxc);
        for (int c = 0; c < maxc; c++) begin
            drive_mem();
            if (i_resp) i_read = 0;
            if (d_resp) begin d_read = 0; d_write = 0; end
            tick();
            if ((mem_read || mem_write) && !prev_busy && n_st < 8) begin
                st_addr[n_st] = mem_addr;
                st_cyc[n_st]  = cyc;
                n_st++;
            end
            prev_busy = mem_read || mem_write;
            if (i_resp) begin n_i++; i_line = i_rdata; t_iresp = cyc; end
            if (d_resp) begin n_d++; d_line = d_rdata; t_dresp = cyc; end
        end
    endtask

    task automatic rand_drive();
        drive_mem();
        if (i_resp) i_read = 0;
        else if (!i_read && $urandom_range(0, 3) == 0) begin
            i_read = 1;
            i_addr = $urandom;
        end
        if (d_resp) begin
            d_read = 0; d_write = 0;
        end else if (!(d_read || d_write) && $urandom_range(0, 3) == 0) begin
            d_addr = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                d_write = 1;
                for (int k = 0; k < 8; k++) d_wdata[32*k +: 32] = $urandom;
            end else begin
                d_read = 1;
            end
        end
    endtask

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] D0 = 64'hD0D0_0000_1111_00D0;
    localparam logic [63:0] D1 = 64'hD1D1_0000_2222_00D1;
    localparam logic [63:0] D2 = 64'hD2D2_0000_3333_00D2;
    localparam logic [63:0] D3 = 64'hD3D3_0000_4444_00D3;

    int t0;

    initial begin
        rst = 1; i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        m_reset();
        dir_mode = 1; dir_lat = 0; dir_gap = 0; wcnt = 0; bidx = 0; t_beat4 = -1;
        dir_beats = '{B1, B2, B3, B4};
        @(negedge clk); @(negedge clk);
        chk_all_zero("reset");
        rst = 0;

        // Icache fill, unaligned address
        clr_log(); t0 = cyc;
        i_addr = 32'h0000_0064; i_read = 1;
        run_dir(12);
        chk("t1_n_iresp", 256'(n_i), 256'(1));
        chk("t1_n_dresp", 256'(n_d), 256'(0));
        chk("t1_addr", 256'(st_addr[0]), 256'(32'h0000_0060));
        chk("t1_start", 256'(st_cyc[0] - t0), 256'(1));
        chk("t1_line", i_line, {B4, B3, B2, B1});

        // Dcache writeback with one idle cycle between beats
        clr_log(); dir_gap = 1;
        d_addr = 32'h0000_1000; d_wdata = {D3, D2, D1, D0}; d_write = 1;
        run_dir(16);
        chk("t2_wbeat0", 256'(wlog[0]), 256'(D0));
        chk("t2_wbeat1", 256'(wlog[1]), 256'(D1));
        chk("t2_wbeat2", 256'(wlog[2]), 256'(D2));
        chk("t2_wbeat3", 256'(wlog[3]), 256'(D3));
        chk("t2_n_dresp", 256'(n_d), 256'(1));
        chk("t2_resp_lat", 256'(t_dresp - t_beat4), 256'(1));
        chk("t2_addr", 256'(st_addr[0]), 256'(32'h0000_1000));

        // Simultaneous D and I reads: D first, I two cycles after d_resp
        clr_log(); dir_gap = 0; dir_lat = 1;
        i_addr = 32'h0000_2040; d_addr = 32'h0000_3088; i_read = 1; d_read = 1;
        run_dir(30);
        chk("t3_n_dresp", 256'(n_d), 256'(1));
        chk("t3_n_iresp", 256'(n_i), 256'(1));
        chk("t3_order", 256'(t_iresp > t_dresp), 256'(1));
        chk("t3_n_bursts", 256'(n_st), 256'(2));
        chk("t3_addr0", 256'(st_addr[0]), 256'(32'h0000_3080));
        chk("t3_addr1", 256'(st_addr[1]), 256'(32'h0000_2040));
        chk("t3_gap", 256'(st_cyc[1] - t_dresp), 256'(2));
        chk("t3_dline", d_line, {B4, B3, B2, B1});
        chk("t3_iline", i_line, {B4, B3, B2, B1});

        // Slow memory: 5-cycle first-beat latency, gaps between beats
        clr_log(); dir_lat = 4; dir_gap = 2;
        dir_beats = '{64'hA1A1_A1A1_A1A1_A1A1, 64'hB2B2_B2B2_B2B2_B2B2,
                      64'hC3C3_C3C3_C3C3_C3C3, 64'hD4D4_D4D4_D4D4_D4D4};
        i_addr = 32'h00AB_CDE7; i_read = 1;
        run_dir(40);
        chk("t4_n_iresp", 256'(n_i), 256'(1));
        chk("t4_addr", 256'(st_addr[0]), 256'(32'h00AB_CDE0));
        chk("t4_line", i_line, {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3,
                                64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1});

        // Reset after the second beat of a read
        clr_log(); dir_lat = 0; dir_gap = 0;
        dir_beats = '{B1, B2, B3, B4};
        i_addr = 32'h0000_0500; i_read = 1;
        run_dir(3);
        chk("t5_busy_before", 256'(mem_read), 256'(1));
        #2 rst = 1;
        #1 chk_all_zero("t5_async");
        m_reset(); i_read = 0; mem_resp = 0;
        @(negedge clk);
        rst = 0;
        clr_log();
        run_dir(6);
        chk("t5_no_resp", 256'(n_i + n_d), 256'(0));
        clr_log();
        i_read = 1;
        run_dir(12);
        chk("t5_n_iresp", 256'(n_i), 256'(1));
        chk("t5_line", i_line, {B4, B3, B2, B1});

        // Stray beats while idle must not advance the counter
        mem_resp = 1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick(); tick();
        clr_log();
        d_addr = 32'h0000_7777; d_read = 1;
        run_dir(12);
        chk("t6_n_dresp", 256'(n_d), 256'(1));
        chk("t6_addr", 256'(st_addr[0]), 256'(32'h0000_7760));
        chk("t6_line", d_line, {B4, B3, B2, B1});

        // Randomized traffic against the model
        dir_mode = 0;
        for (int k = 0; k < 4000; k++) begin
            rand_drive();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
